// File: rtl/sat_pkg.sv
// Shared types and range helpers for the symmetric saturating accumulator.
package sat_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Symmetric two's-complement range: the most negative pattern is never produced.
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -sat_max(w);
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational clamp of a signed sum into the symmetric range [MIN, MAX].
module sat_clamp
  import sat_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] sum_i,
  input  logic         carry_i,
  input  logic         oflow_i,
  output logic [W-1:0] val_o,
  output logic         engaged_o
);

  localparam logic [W-1:0] MAX_V     = W'(sat_max(W));
  localparam logic [W-1:0] MIN_V     = W'(sat_min(W));
  localparam logic [W-1:0] ILLEGAL_V = {1'b1, {(W-1){1'b0}}};

  // carry_i is the true sign of the widened sum, so it picks the rail on overflow.
  always_comb begin
    val_o     = sum_i;
    engaged_o = 1'b0;
    if (oflow_i) begin
      engaged_o = 1'b1;
      val_o     = carry_i ? MIN_V : MAX_V;
    end else if (sum_i == ILLEGAL_V) begin
      engaged_o = 1'b1;
      val_o     = MIN_V;
    end
  end

endmodule

// File: rtl/sat_accumulator.sv
// Saturating add/subtract accumulator with a one-deep valid/ready output stage
// and a sticky count of clamp events.
module sat_accumulator
  import sat_pkg::*;
#(
  parameter int WIDTH_SUM = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_80,
  input  logic                 rst_n_80,
  input  logic                 in_valid_80,
  output logic                 in_ready_80,
  input  logic [WIDTH_SUM-1:0] in_data_80,
  input  logic                 sub_80,
  input  logic                 clear_80,
  output logic [WIDTH_SUM-1:0] acc_80,
  output logic                 out_valid_80,
  input  logic                 out_ready_80,
  output logic                 sat_flag_80,
  output logic [CNT_WIDTH-1:0] sat_count_80,
  output state_e               state_dbg_80
);

  localparam logic [WIDTH_SUM-1:0] MIN_V     = WIDTH_SUM'(sat_min(WIDTH_SUM));
  localparam logic [WIDTH_SUM-1:0] ILLEGAL_V = {1'b1, {(WIDTH_SUM-1){1'b0}}};

  state_e                 state_q, state_d;
  logic [WIDTH_SUM-1:0]   acc_q, acc_d;
  logic                   flag_q, flag_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic                   accept;
  logic [WIDTH_SUM-1:0]   data_fix;
  logic [WIDTH_SUM-1:0]   op;
  logic [WIDTH_SUM-1:0]   base;
  logic [WIDTH_SUM:0]     sum_ext;
  logic                   oflow;
  logic [WIDTH_SUM-1:0]   clamp_val;
  logic                   clamp_eng;

  // Handshakes: a transfer happens on a cycle where valid and ready are both 1;
  // valid never waits on ready, and a held result keeps its data stable.
  assign in_ready_80  = rst_n_80 & ((state_q == ST_EMPTY) | out_ready_80);
  assign accept       = in_valid_80 & in_ready_80;
  assign out_valid_80 = (state_q == ST_FULL);
  assign acc_80       = acc_q;
  assign sat_flag_80  = flag_q;
  assign sat_count_80 = cnt_q;
  assign state_dbg_80 = state_q;

  always_comb begin
    data_fix = (in_data_80 == ILLEGAL_V) ? MIN_V : in_data_80;
    op       = sub_80 ? -data_fix : data_fix;
    base     = clear_80 ? '0 : acc_q;
    sum_ext  = {base[WIDTH_SUM-1], base} + {op[WIDTH_SUM-1], op};
    oflow    = sum_ext[WIDTH_SUM] ^ sum_ext[WIDTH_SUM-1];
  end

  sat_clamp #(
    .W (WIDTH_SUM)
  ) u_clamp (
    .sum_i     (sum_ext[WIDTH_SUM-1:0]),
    .carry_i   (sum_ext[WIDTH_SUM]),
    .oflow_i   (oflow),
    .val_o     (clamp_val),
    .engaged_o (clamp_eng)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = ST_FULL;
      acc_d   = clamp_val;
      flag_d  = clamp_eng;
      if (clamp_eng && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end else begin
      // A bare clear only zeroes the value; handshake and statistics are untouched.
      if (clear_80) begin
        acc_d = '0;
      end
      if ((state_q == ST_FULL) && out_ready_80) begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk_80 or negedge rst_n_80) begin
    if (!rst_n_80) begin
      state_q <= ST_EMPTY;
      acc_q   <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sat_accumulator.sv
// Randomized and directed bench for sat_accumulator against an integer-arithmetic model.
module tb_sat_accumulator;
  import sat_pkg::*;

  localparam int W    = 4;
  localparam int CW   = 8;
  localparam int MAXV = 7;
  localparam int CMAX = 255;

  logic          clk_80;
  logic          rst_n_80;
  logic          in_valid_80;
  logic          in_ready_80;
  logic [W-1:0]  in_data_80;
  logic          sub_80;
  logic          clear_80;
  logic [W-1:0]  acc_80;
  logic          out_valid_80;
  logic          out_ready_80;
  logic          sat_flag_80;
  logic [CW-1:0] sat_count_80;
  state_e        state_dbg_80;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_acc   = 0;
  int m_valid = 0;
  int m_flag  = 0;
  int m_cnt   = 0;

  sat_accumulator #(
    .WIDTH_SUM (W),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_80       (clk_80),
    .rst_n_80     (rst_n_80),
    .in_valid_80  (in_valid_80),
    .in_ready_80  (in_ready_80),
    .in_data_80   (in_data_80),
    .sub_80       (sub_80),
    .clear_80     (clear_80),
    .acc_80       (acc_80),
    .out_valid_80 (out_valid_80),
    .out_ready_80 (out_ready_80),
    .sat_flag_80  (sat_flag_80),
    .sat_count_80 (sat_count_80),
    .state_dbg_80 (state_dbg_80)
  );

  // Clock / reset
  initial clk_80 = 1'b0;
  always #5 clk_80 = ~clk_80;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string ctx);
    int a;
    a = $signed(acc_80);
    check_eq({ctx, " acc"}, a, m_acc);
    check_eq({ctx, " out_valid"}, int'(out_valid_80), m_valid);
    check_eq({ctx, " sat_flag"}, int'(sat_flag_80), m_flag);
    check_eq({ctx, " sat_count"}, int'(sat_count_80), m_cnt);
    check_eq({ctx, " state"}, int'(state_dbg_80), m_valid);
  endtask

  task automatic model_reset();
    m_acc   = 0;
    m_valid = 0;
    m_flag  = 0;
    m_cnt   = 0;
  endtask

  // Called at posedge+1; drives one cycle and checks ready before and outputs after the edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic s,
                      input logic c, input logic r, input string ctx);
    int exp_ready, opv, base, sum, eng;
    in_valid_80  = v;
    in_data_80   = d;
    sub_80       = s;
    clear_80     = c;
    out_ready_80 = r;
    #1;
    exp_ready = (m_valid == 0 || r) ? 1 : 0;
    check_eq({ctx, " in_ready"}, int'(in_ready_80), exp_ready);
    if (v && exp_ready == 1) begin
      opv = $signed(d);
      if (opv < -MAXV) opv = -MAXV;
      if (s) opv = -opv;
      base = c ? 0 : m_acc;
      sum  = base + opv;
      eng  = 0;
      if (sum > MAXV) begin
        sum = MAXV;
        eng = 1;
      end else if (sum < -MAXV) begin
        sum = -MAXV;
        eng = 1;
      end
      m_acc   = sum;
      m_flag  = eng;
      m_valid = 1;
      if (eng == 1 && m_cnt < CMAX) m_cnt++;
    end else begin
      if (c) m_acc = 0;
      if (m_valid == 1 && r) m_valid = 0;
    end
    @(posedge clk_80);
    #1;
    check_outputs(ctx);
  endtask

  // Assert reset away from any edge and check outputs respond without a clock.
  task automatic async_reset(input string ctx);
    #2;
    rst_n_80 = 1'b0;
    #1;
    model_reset();
    check_outputs(ctx);
    check_eq({ctx, " in_ready"}, int'(in_ready_80), 0);
    @(posedge clk_80);
    #1;
    rst_n_80 = 1'b1;
  endtask

  initial begin
    rst_n_80     = 1'b0;
    in_valid_80  = 1'b0;
    in_data_80   = '0;
    sub_80       = 1'b0;
    clear_80     = 1'b0;
    out_ready_80 = 1'b0;
    repeat (3) @(posedge clk_80);
    #1;
    check_outputs("reset");
    check_eq("reset in_ready", int'(in_ready_80), 0);
    rst_n_80 = 1'b1;

    // Add +3 three times; first accept on the first edge after reset release
    step(1'b1, 4'd3, 1'b0, 1'b0, 1'b1, "add3_a");
    step(1'b1, 4'd3, 1'b0, 1'b0, 1'b1, "add3_b");
    step(1'b1, 4'd3, 1'b0, 1'b0, 1'b1, "add3_c");

    // Clear with -5, then subtract +5 underflows to MIN
    step(1'b1, 4'b1011, 1'b0, 1'b1, 1'b1, "clr_m5");
    step(1'b1, 4'd5, 1'b1, 1'b0, 1'b1, "sub5");

    // Illegal operand 1000 acts as -7
    step(1'b1, 4'b1000, 1'b0, 1'b1, 1'b1, "illegal_add");
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, "bare_clear");
    step(1'b1, 4'b1000, 1'b1, 1'b0, 1'b1, "illegal_sub");

    // Stall with out_ready low, then release with a same-cycle accept
    step(1'b1, 4'd2, 1'b0, 1'b1, 1'b0, "stall_load");
    for (int i = 0; i < 5; i++) step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, "stall_hold");
    step(1'b1, 4'd4, 1'b0, 1'b0, 1'b1, "stall_release");

    // Clear with accept uses base 0
    step(1'b1, 4'd2, 1'b0, 1'b1, 1'b1, "clr_accept");

    // Negative illegal-result fixup: -4 + -4 lands on 1000
    step(1'b1, 4'b1100, 1'b0, 1'b1, 1'b1, "neg4");
    step(1'b1, 4'b1100, 1'b0, 1'b0, 1'b1, "neg8_fix");

    // Drive the counter to its ceiling
    for (int i = 0; i < 260; i++) step(1'b1, 4'd7, 1'b0, 1'b0, 1'b1, "cnt_sat");
    check_eq("cnt_ceiling", int'(sat_count_80), CMAX);

    // Reset mid-transfer while a result is held
    step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, "pre_reset");
    async_reset("mid_reset");
    step(1'b1, 4'd1, 1'b1, 1'b0, 1'b1, "post_reset");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 2) != 0), "rand");
      if (i == 300) async_reset("rand_reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
